// File: rtl/is_pkg.sv
// rtl/is_pkg.sv - shared types, defaults and lane-delay helper for the input sequencer
package is_pkg;

  localparam int D_W_DEF = 8;
  localparam int N_DEF   = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_STREAM = 3'd2,
    S_DRAIN  = 3'd3,
    S_DONE   = 3'd4
  } is_feed_state_t;

  // Lane r of the left edge is delayed r+1 cycles so the array sees a diagonal wavefront.
  function automatic int lane_delay(input int r);
    return r + 1;
  endfunction

endpackage

// File: rtl/is_feeder_if.sv
// rtl/is_feeder_if.sv - weight and activation buffer streams into the sequencer
interface is_feeder_if #(
  parameter int D_W = 8,
  parameter int N   = 4
);
  logic             w_valid;
  logic             w_ready;
  logic [D_W*N-1:0] w_row;
  logic             a_valid;
  logic             a_ready;
  logic [D_W*N-1:0] a_row;

  // Buffer side
  modport master (
    output w_valid, w_row, a_valid, a_row,
    input  w_ready, a_ready
  );

  // Sequencer side
  modport slave (
    input  w_valid, w_row, a_valid, a_row,
    output w_ready, a_ready
  );
endinterface

// File: rtl/is_skew_line.sv
// rtl/is_skew_line.sv - data-plus-valid shift register for one left-edge lane
module is_skew_line #(
  parameter int D_W   = 8,
  parameter int DEPTH = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [D_W-1:0] data_i,
  input  logic           vld_i,
  output logic [D_W-1:0] data_o,
  output logic           vld_o
);
  logic [D_W-1:0] data_q [DEPTH];
  logic           vld_q  [DEPTH];

  // Free-running shift: every cycle injects either an element or a zero bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        vld_q[i]  <= 1'b0;
      end
    end else begin
      data_q[0] <= data_i;
      vld_q[0]  <= vld_i;
      for (int i = 1; i < DEPTH; i++) begin
        data_q[i] <= data_q[i-1];
        vld_q[i]  <= vld_q[i-1];
      end
    end
  end

  assign data_o = data_q[DEPTH-1];
  assign vld_o  = vld_q[DEPTH-1];
endmodule

// File: rtl/is_feeder.sv
// rtl/is_feeder.sv - weight loader and skewed activation streamer for the systolic array
module is_feeder
  import is_pkg::*;
#(
  parameter int D_W = D_W_DEF,
  parameter int N   = N_DEF,
  parameter int K   = 16,
  localparam int VW = $clog2(K + 1),
  localparam int CW = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst,
  is_feeder_if.slave       bus,
  input  logic             start,
  input  logic [VW-1:0]    num_vec,
  output logic             load_weight,
  output logic [D_W*N-1:0] m1,
  output logic [D_W*N-1:0] m0,
  output logic [N-1:0]     m0_vld,
  output logic             busy,
  output logic             done
);
  localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
  localparam logic [VW-1:0] K_SAT    = VW'(K);

  is_feed_state_t   state_q;
  logic [CW-1:0]    w_cnt_q;
  logic [CW-1:0]    drn_cnt_q;
  logic [VW-1:0]    vec_cnt_q;
  logic [VW-1:0]    num_vec_q;
  logic             load_weight_q;
  logic [D_W*N-1:0] m1_q;

  logic          w_hs;
  logic          a_hs;
  logic [VW-1:0] num_vec_sat;

  assign num_vec_sat = (num_vec > K_SAT) ? K_SAT : num_vec;

  assign bus.w_ready = (state_q == S_LOAD);
  assign bus.a_ready = (state_q == S_STREAM) && (vec_cnt_q < num_vec_q);
  assign w_hs        = bus.w_valid & bus.w_ready;
  assign a_hs        = bus.a_valid & bus.a_ready;

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign load_weight = load_weight_q;
  assign m1          = m1_q;

  // Job sequencing: weight rows, then vectors, then N drain cycles to flush the skew.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      w_cnt_q   <= '0;
      drn_cnt_q <= '0;
      vec_cnt_q <= '0;
      num_vec_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            num_vec_q <= num_vec_sat;
            w_cnt_q   <= '0;
            drn_cnt_q <= '0;
            vec_cnt_q <= '0;
            state_q   <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_hs) begin
            w_cnt_q <= w_cnt_q + CW'(1);
            if (w_cnt_q == CNT_LAST) begin
              state_q <= (num_vec_q == '0) ? S_DONE : S_STREAM;
            end
          end
        end
        S_STREAM: begin
          if (a_hs) begin
            vec_cnt_q <= vec_cnt_q + VW'(1);
            if ((vec_cnt_q + VW'(1)) == num_vec_q) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (drn_cnt_q == CNT_LAST) begin
            state_q <= S_DONE;
          end else begin
            drn_cnt_q <= drn_cnt_q + CW'(1);
          end
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Top edge: a row is shifted only in the cycle after its handshake; otherwise the array holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_weight_q <= 1'b0;
      m1_q          <= '0;
    end else begin
      load_weight_q <= w_hs;
      m1_q          <= w_hs ? bus.w_row : '0;
    end
  end

  for (genvar r = 0; r < N; r++) begin : g_lane
    logic [D_W-1:0] lane_in;
    assign lane_in = a_hs ? bus.a_row[r*D_W +: D_W] : '0;

    is_skew_line #(
      .D_W  (D_W),
      .DEPTH(lane_delay(r))
    ) u_line (
      .clk   (clk),
      .rst   (rst),
      .data_i(lane_in),
      .vld_i (a_hs),
      .data_o(m0[r*D_W +: D_W]),
      .vld_o (m0_vld[r])
    );
  end
endmodule

// File: tb/tb_is_feeder.sv
// tb/tb_is_feeder.sv - directed self-checking bench for is_feeder
module tb_is_feeder;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [4:0]  num_vec;
  logic        load_weight;
  logic [31:0] m1;
  logic [31:0] m0;
  logic [3:0]  m0_vld;
  logic        busy;
  logic        done;

  is_feeder_if #(.D_W(8), .N(4)) bus ();

  is_feeder #(.D_W(8), .N(4), .K(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .start      (start),
    .num_vec    (num_vec),
    .load_weight(load_weight),
    .m1         (m1),
    .m0         (m0),
    .m0_vld     (m0_vld),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] wrows [4];
  logic        lw_r   [64];
  logic [31:0] m1_r   [64];
  logic [31:0] m0_r   [64];
  logic [3:0]  vld_r  [64];
  logic        done_r [64];
  logic        busy_r [64];
  logic        ar_r   [64];
  int nw;
  int na;

  function automatic logic [31:0] vec_of(input int i);
    return {8'(4*i + 4), 8'(4*i + 3), 8'(4*i + 2), 8'(4*i + 1)};
  endfunction

  // Cycle 0 carries start; weights offered from cycle 1, vectors from cycle 6.
  task automatic run_job(input int nv, input int supply, input int gap_at,
                         input int gap_len, input bit poke, input int ncyc);
    int hold;
    bit whs;
    bit ahs;
    nw = 0;
    na = 0;
    hold = 0;
    for (int c = 0; c < ncyc; c++) begin
      start       = (c == 0) || (poke && (c == 2 || c == 7 || c == 13));
      num_vec     = (poke && c >= 1) ? 5'd9 : 5'(nv);
      bus.w_valid = (c >= 1) && (nw < 4);
      bus.w_row   = (nw < 4) ? wrows[nw] : 32'h0;
      bus.a_valid = (c >= 6) && (na < supply) && (hold == 0);
      bus.a_row   = vec_of(na);
      @(negedge clk);
      lw_r[c]   = load_weight;
      m1_r[c]   = m1;
      m0_r[c]   = m0;
      vld_r[c]  = m0_vld;
      done_r[c] = done;
      busy_r[c] = busy;
      ar_r[c]   = bus.a_ready;
      whs = bus.w_valid && bus.w_ready;
      ahs = bus.a_valid && bus.a_ready;
      @(posedge clk);
      #1;
      if (hold > 0) hold--;
      if (whs) nw++;
      if (ahs) begin
        na++;
        if (na == gap_at) hold = gap_len;
      end
    end
    start = 1'b0;
    bus.w_valid = 1'b0;
    bus.a_valid = 1'b0;
  endtask

  task automatic test_reset;
    @(posedge clk);
    #1;
    n_cmp++; if (load_weight !== 1'b0) begin n_bad++; $display("FAIL rst_lw got=%b exp=0", load_weight); end
    n_cmp++; if (m1 !== 32'h0) begin n_bad++; $display("FAIL rst_m1 got=%h exp=0", m1); end
    n_cmp++; if (m0 !== 32'h0) begin n_bad++; $display("FAIL rst_m0 got=%h exp=0", m0); end
    n_cmp++; if (m0_vld !== 4'h0) begin n_bad++; $display("FAIL rst_vld got=%b exp=0", m0_vld); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done got=%b exp=0", done); end
    n_cmp++; if (bus.w_ready !== 1'b0) begin n_bad++; $display("FAIL rst_wready got=%b exp=0", bus.w_ready); end
    n_cmp++; if (bus.a_ready !== 1'b0) begin n_bad++; $display("FAIL rst_aready got=%b exp=0", bus.a_ready); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_weight_load;
    logic [31:0] exp_m1;
    run_job(3, 3, -1, 0, 1'b0, 16);
    for (int c = 0; c < 16; c++) begin
      exp_m1 = (c == 2) ? 32'h44444444 : (c == 3) ? 32'h33333333 :
               (c == 4) ? 32'h22222222 : (c == 5) ? 32'h11111111 : 32'h0;
      n_cmp++;
      if (lw_r[c] !== (c >= 2 && c <= 5)) begin
        n_bad++; $display("FAIL wload_lw c=%0d got=%b exp=%b", c, lw_r[c], (c >= 2 && c <= 5));
      end
      n_cmp++;
      if (m1_r[c] !== exp_m1) begin
        n_bad++; $display("FAIL wload_m1 c=%0d got=%h exp=%h", c, m1_r[c], exp_m1);
      end
    end
  endtask

  task automatic test_skew;
    logic [31:0] w;
    logic [7:0]  exp_d;
    bit          exp_v;
    int          idx;
    run_job(3, 3, -1, 0, 1'b0, 16);
    w = m0_r[7];  n_cmp++; if (w[7:0] !== 8'd1)    begin n_bad++; $display("FAIL skew_l0_c7 got=%0d exp=1", w[7:0]); end
    w = m0_r[9];  n_cmp++; if (w[7:0] !== 8'd9)    begin n_bad++; $display("FAIL skew_l0_c9 got=%0d exp=9", w[7:0]); end
    w = m0_r[10]; n_cmp++; if (w[31:24] !== 8'd4)  begin n_bad++; $display("FAIL skew_l3_c10 got=%0d exp=4", w[31:24]); end
    w = m0_r[12]; n_cmp++; if (w[31:24] !== 8'd12) begin n_bad++; $display("FAIL skew_l3_c12 got=%0d exp=12", w[31:24]); end
    for (int c = 0; c < 16; c++) begin
      for (int r = 0; r < 4; r++) begin
        idx   = c - 7 - r;
        exp_v = (idx >= 0) && (idx < 3);
        exp_d = exp_v ? 8'(4*idx + r + 1) : 8'h00;
        w = m0_r[c];
        n_cmp++;
        if (w[r*8 +: 8] !== exp_d || vld_r[c][r] !== exp_v) begin
          n_bad++;
          $display("FAIL skew_lane c=%0d r=%0d got=%0d/%b exp=%0d/%b", c, r, w[r*8 +: 8], vld_r[c][r], exp_d, exp_v);
        end
      end
      n_cmp++;
      if (done_r[c] !== (c == 13)) begin
        n_bad++; $display("FAIL skew_done c=%0d got=%b exp=%b", c, done_r[c], (c == 13));
      end
      n_cmp++;
      if (busy_r[c] !== (c >= 1 && c <= 13)) begin
        n_bad++; $display("FAIL skew_busy c=%0d got=%b exp=%b", c, busy_r[c], (c >= 1 && c <= 13));
      end
    end
  endtask

  task automatic test_bubbles;
    logic [31:0] w;
    logic [7:0]  exp_d;
    bit          exp_v;
    int          d;
    run_job(3, 3, 1, 2, 1'b0, 18);
    for (int c = 0; c < 18; c++) begin
      for (int r = 0; r < 4; r++) begin
        d     = c - r;
        exp_v = (d == 7) || (d == 10) || (d == 11);
        exp_d = (d == 7) ? 8'(1 + r) : (d == 10) ? 8'(5 + r) : (d == 11) ? 8'(9 + r) : 8'h00;
        w = m0_r[c];
        n_cmp++;
        if (w[r*8 +: 8] !== exp_d || vld_r[c][r] !== exp_v) begin
          n_bad++;
          $display("FAIL bubble_lane c=%0d r=%0d got=%0d/%b exp=%0d/%b", c, r, w[r*8 +: 8], vld_r[c][r], exp_d, exp_v);
        end
      end
      n_cmp++;
      if (done_r[c] !== (c == 15)) begin
        n_bad++; $display("FAIL bubble_done c=%0d got=%b exp=%b", c, done_r[c], (c == 15));
      end
    end
  endtask

  task automatic test_edge_counts;
    logic [31:0] w;
    run_job(0, 0, -1, 0, 1'b0, 8);
    for (int c = 0; c < 8; c++) begin
      n_cmp++;
      if (done_r[c] !== (c == 5) || vld_r[c] !== 4'h0 || ar_r[c] !== 1'b0) begin
        n_bad++;
        $display("FAIL zero_vec c=%0d got done=%b vld=%b ar=%b exp done=%b vld=0 ar=0", c, done_r[c], vld_r[c], ar_r[c], (c == 5));
      end
      n_cmp++;
      if (busy_r[c] !== (c >= 1 && c <= 5)) begin
        n_bad++; $display("FAIL zero_busy c=%0d got=%b exp=%b", c, busy_r[c], (c >= 1 && c <= 5));
      end
    end
    run_job(19, 19, -1, 0, 1'b0, 30);
    n_cmp++; if (na !== 16) begin n_bad++; $display("FAIL sat_count got=%0d exp=16", na); end
    w = m0_r[25];
    n_cmp++; if (w[31:24] !== 8'd64 || vld_r[25][3] !== 1'b1) begin
      n_bad++; $display("FAIL sat_last got=%0d/%b exp=64/1", w[31:24], vld_r[25][3]);
    end
    n_cmp++; if (vld_r[26] !== 4'h0) begin n_bad++; $display("FAIL sat_tail got=%b exp=0000", vld_r[26]); end
    n_cmp++; if (ar_r[22] !== 1'b0) begin n_bad++; $display("FAIL sat_aready got=%b exp=0", ar_r[22]); end
    for (int c = 20; c < 30; c++) begin
      n_cmp++;
      if (done_r[c] !== (c == 26)) begin
        n_bad++; $display("FAIL sat_done c=%0d got=%b exp=%b", c, done_r[c], (c == 26));
      end
    end
  endtask

  task automatic test_start_ignored;
    int vcnt;
    run_job(3, 9, -1, 0, 1'b1, 18);
    vcnt = 0;
    for (int c = 0; c < 18; c++) begin
      if (vld_r[c][0]) vcnt++;
      n_cmp++;
      if (done_r[c] !== (c == 13) || busy_r[c] !== (c >= 1 && c <= 13) || lw_r[c] !== (c >= 2 && c <= 5)) begin
        n_bad++;
        $display("FAIL start_ign c=%0d got done=%b busy=%b lw=%b", c, done_r[c], busy_r[c], lw_r[c]);
      end
    end
    n_cmp++; if (na !== 3) begin n_bad++; $display("FAIL start_ign_count got=%0d exp=3", na); end
    n_cmp++; if (vcnt !== 3) begin n_bad++; $display("FAIL start_ign_vld got=%0d exp=3", vcnt); end
  endtask

  task automatic test_reset_abort;
    run_job(3, 3, -1, 0, 1'b0, 8);
    n_cmp++; if (busy !== 1'b1 || m0_vld !== 4'b0011) begin
      n_bad++; $display("FAIL abort_pre got busy=%b vld=%b exp busy=1 vld=0011", busy, m0_vld);
    end
    #2;
    rst = 1'b1;
    #1;
    n_cmp++; if (m0 !== 32'h0 || m0_vld !== 4'h0) begin
      n_bad++; $display("FAIL abort_m0 got=%h/%b exp=0/0", m0, m0_vld);
    end
    n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || bus.a_ready !== 1'b0 || bus.w_ready !== 1'b0) begin
      n_bad++; $display("FAIL abort_ctl got busy=%b done=%b ar=%b wr=%b exp 0", busy, done, bus.a_ready, bus.w_ready);
    end
    n_cmp++; if (load_weight !== 1'b0 || m1 !== 32'h0) begin
      n_bad++; $display("FAIL abort_m1 got=%b/%h exp=0/0", load_weight, m1);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || m0_vld !== 4'h0) begin
        n_bad++; $display("FAIL abort_idle c=%0d got busy=%b done=%b vld=%b exp 0", c, busy, done, m0_vld);
      end
      @(posedge clk);
      #1;
    end
    run_job(0, 0, -1, 0, 1'b0, 8);
    n_cmp++; if (done_r[5] !== 1'b1) begin n_bad++; $display("FAIL abort_recover got=%b exp=1", done_r[5]); end
  endtask

  initial begin
    rst         = 1'b1;
    start       = 1'b0;
    num_vec     = 5'd0;
    bus.w_valid = 1'b0;
    bus.w_row   = 32'h0;
    bus.a_valid = 1'b0;
    bus.a_row   = 32'h0;
    wrows[0] = 32'h44444444;
    wrows[1] = 32'h33333333;
    wrows[2] = 32'h22222222;
    wrows[3] = 32'h11111111;
    test_reset;
    test_weight_load;
    test_skew;
    test_bubbles;
    test_edge_counts;
    test_start_ignored;
    test_reset_abort;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/is_feeder.md
# is_feeder

Input sequencer for the input-stationary systolic array. It drives the array's left and top IO and its global `load_weight`. Per job it first shifts N weight rows down through the array (`load_weight` high), then streams activation vectors into the left edge with the per-row diagonal skew the array needs. It then drains the skew pipeline and pulses `done`. It sits directly upstream of the array and below the on-chip weight and activation buffers. Both buffers connect through valid/ready handshakes.

## Interface
- `D_W`, 8, element width
- `N`, 4, array size; number of lanes
- `K`, 16, maximum activation vectors per job
- `clk` in 1, sole clock, rising edge
- `rst` in 1, reset (asynchronous, active-high)
- `start` in 1, job start pulse; sampled only in IDLE
- `num_vec` in $clog2(K+1), number of activation vectors in the job; latched on `start`; values above K saturate to K
- `w_valid` in 1 / `w_ready` out 1 / `w_row` in D_W×N, weight-row stream, bottom row (array row N-1) first
- `a_valid` in 1 / `a_ready` out 1 / `a_row` in D_W×N, activation-vector stream; element r feeds array row r
- `load_weight` out 1, to array
- `m1` out D_W×N, to array top IO
- `m0` out D_W×N, to array left IO
- `m0_vld` out N, per-lane valid tag travelling with `m0`; for the downstream deskew
- `busy` out 1, high in every state except IDLE
- `done` out 1, one-cycle job-complete pulse

## Operation
- FSM states are IDLE, LOAD, STREAM, DRAIN and DONE.
- IDLE → LOAD on `start`. `start` is ignored in every other state.
- LOAD: `w_ready`=1. A handshake is `w_valid`&`w_ready`. Each handshake counts one row. After the Nth handshake the FSM goes to STREAM, or to DONE if the latched `num_vec`=0.
- Each accepted weight row appears on `m1` one cycle later with `load_weight`=1.
- In cycles with no weight handshake, `load_weight`=0 and `m1`=0, so the array holds its weights. Upstream gaps are therefore harmless.
- STREAM: `a_ready`=1 while accepted < `num_vec`. The last handshake moves the FSM to DRAIN in the next cycle.
- Element r of a vector accepted in cycle t appears on `m0[r]` in cycle t+1+r, with `m0_vld[r]`=1.
- A cycle with no handshake injects zeros with `m0_vld`=0 on every lane, at the same skewed positions.
- DRAIN: `a_ready`=0. The FSM stays for exactly N cycles, feeding zeros and invalid tags into the skew lines. It then goes to DONE.
- DONE: `done`=1 for one cycle, then the FSM returns to IDLE. `start` in DONE is ignored.
- `w_ready`=0 outside LOAD. `a_ready`=0 outside STREAM.
- No arithmetic; data passes through unmodified.
- Counters:
  - Weight-row counter: $clog2(N+1) bits.
  - Vector counter: $clog2(K+1) bits.
  - Drain counter: $clog2(N+1) bits.
  - All counters clear on entry to LOAD.

## Timing
- Reset state: FSM in IDLE and all skew stages cleared. All outputs are 0 during and after reset: `load_weight`, `m1`, `m0`, `m0_vld`, `w_ready`, `a_ready`, `busy`, `done`.
- `rst` mid-job aborts immediately, with no `done` pulse. Partial array weights are the owner's concern.
- `w_ready`, `a_ready` and `busy` are decoded from the registered state.
- `m1`, `load_weight`, `m0` and `m0_vld` are registered.
- Latency:
  - Weight row: 1 cycle from handshake to `m1`.
  - Activation element r: 1+r cycles from handshake to `m0[r]`.
- Last weight handshake in cycle t: `load_weight` is high in t+1 and STREAM begins in t+1. An activation accepted in t+1 reaches `m0[0]` in t+2, after the final weight shift.
- Last activation handshake in cycle t: DRAIN covers t+1..t+N; lane N-1 emits the last element in t+N; `done` is high in t+N+1; IDLE in t+N+2.
- Minimum job with `num_vec`=0 and back-to-back weights: `start` in cycle 0; LOAD 1..N; DONE N+1.

## Structure
- Package `is_pkg` holds:
  - the FSM state enum `is_feed_state_t`;
  - default `D_W`/`N` constants;
  - the function returning lane delay (r+1).
- Sub-module `is_skew_line`, parameterised by `D_W` and `DEPTH`. It is a data-plus-valid shift register with async clear, instantiated per lane with `DEPTH`=r+1.
- Control FSM and counters live in `is_feeder`.

## Test plan
- **Reset.** Assert `rst` asynchronously mid-cycle during STREAM. Required: all outputs 0 immediately; FSM in IDLE after release; no `done`.
- **Weight load.** N=4, `start`, then rows 0x44.., 0x33.., 0x22.., 0x11.. back-to-back. Required: `load_weight` high for cycles 2–5 and `m1` equals each row one cycle after its handshake.
- **Skew.** `num_vec`=3, vectors {1,2,3,4}, {5,6,7,8}, {9,10,11,12} back-to-back from cycle 6. Required:
  - `m0[0]`=1,5,9 in cycles 7–9;
  - `m0[3]`=4,8,12 in cycles 10–12;
  - `m0_vld` marks exactly those cycles;
  - `done` in cycle 13.
- **Bubbles.** Deassert `a_valid` for 2 cycles between vectors. Required: each lane shows a 2-cycle `m0_vld`=0 gap of zeros at its skewed position; `done` is delayed by 2 cycles.
- **Edge counts.** `num_vec`=0 goes LOAD→DONE with no `m0_vld`. `num_vec`=K+3 accepts exactly K vectors.
- **Start ignored.** Assert `start` during LOAD, STREAM and DONE, and change `num_vec` mid-job. Required: no restart and the latched count is unchanged.
